// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU datapath types: word width, byte count per word
//               and the fetch-unit state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int WBYTES = WORD_W / 8;

  typedef logic [WORD_W-1:0] word_t;

  // FETCH  : requesting from the I-cache every cycle
  // HOLD   : a fetched word is parked in the skid buffer waiting for decode
  // HALTED : fetch permanently stopped until reset
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if
// Description : Bundle of fetch-unit signals; the fu modport is the fetch
//               unit's view (PC/cache/hazard inputs, IF/ID outputs).
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if;
  import cpu_types_pkg::*;

  word_t cpc;
  word_t pc_plus;
  word_t imemload;
  logic  ihit;
  logic  stall;
  logic  flush;
  logic  halt;
  logic  imemREN;
  word_t imemaddr;
  logic  pc_wen;
  word_t instr_id;
  word_t pc_plus_id;
  logic  valid_id;
  logic  halted;
  word_t fetch_count;

  modport fu (
    input  cpc, pc_plus, imemload, ihit, stall, flush, halt,
    output imemREN, imemaddr, pc_wen, instr_id, pc_plus_id, valid_id,
           halted, fetch_count
  );

endinterface : fetch_if
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid
// Description : One-entry skid buffer holding an instruction word and its
//               pc_plus while decode is stalled. Clear beats load.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  i_load,
  input  logic  i_clear,
  input  word_t i_instr,
  input  word_t i_pc_plus,
  output word_t o_instr,
  output word_t o_pc_plus
);

  word_t instr_q, instr_d;
  word_t pc_plus_q, pc_plus_d;

  // Next-entry selection: clear wins so a flush always discards the entry
  always_comb begin
    instr_d   = instr_q;
    pc_plus_d = pc_plus_q;
    if (i_clear) begin
      instr_d   = '0;
      pc_plus_d = '0;
    end else if (i_load) begin
      instr_d   = i_instr;
      pc_plus_d = i_pc_plus;
    end
  end

  // Entry storage, emptied immediately on reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_q   <= '0;
      pc_plus_q <= '0;
    end else begin
      instr_q   <= instr_d;
      pc_plus_q <= pc_plus_d;
    end
  end

  assign o_instr   = instr_q;
  assign o_pc_plus = pc_plus_q;

endmodule : fetch_skid
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Issues I-cache reads, owns the
//               IF/ID register, parks a word in a skid buffer while decode
//               stalls, and handles flush and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import cpu_types_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  fetch_if.fu  fuif
);

  fetch_state_t state_q, state_d;
  word_t        instr_id_q, instr_id_d;
  word_t        pc_plus_id_q, pc_plus_id_d;
  logic         valid_id_q, valid_id_d;
  word_t        fetch_count_q, fetch_count_d;

  logic  skid_load;
  logic  skid_clear;
  word_t skid_instr;
  word_t skid_pc_plus;

  logic  imem_ren;
  logic  pc_wen;

  fetch_skid u_skid (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_load    (skid_load),
    .i_clear   (skid_clear),
    .i_instr   (fuif.imemload),
    .i_pc_plus (fuif.pc_plus),
    .o_instr   (skid_instr),
    .o_pc_plus (skid_pc_plus)
  );

  // Next-state, IF/ID update and combinational handshake outputs
  always_comb begin
    state_d       = state_q;
    instr_id_d    = instr_id_q;
    pc_plus_id_d  = pc_plus_id_q;
    valid_id_d    = valid_id_q;
    fetch_count_d = fetch_count_q;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    imem_ren      = (state_q == FETCH);
    // The PC moves on a redirect, or whenever a word is accepted into
    // either IF/ID or the skid buffer; a halting cycle keeps the PC put.
    pc_wen        = (fuif.flush && (state_q != HALTED)) ||
                    ((state_q == FETCH) && fuif.ihit && !fuif.halt);

    unique case (state_q)
      FETCH: begin
        if (fuif.flush) begin
          instr_id_d   = '0;
          pc_plus_id_d = '0;
          valid_id_d   = 1'b0;
          skid_clear   = 1'b1;
        end else if (fuif.halt) begin
          instr_id_d   = '0;
          pc_plus_id_d = '0;
          valid_id_d   = 1'b0;
          skid_clear   = 1'b1;
          state_d      = HALTED;
        end else if (fuif.ihit && !fuif.stall) begin
          instr_id_d    = fuif.imemload;
          pc_plus_id_d  = fuif.pc_plus;
          valid_id_d    = 1'b1;
          fetch_count_d = fetch_count_q + word_t'(1);
        end else if (fuif.ihit) begin
          // Decode busy: park the word so the cache result is not lost
          skid_load = 1'b1;
          state_d   = HOLD;
        end else if (!fuif.stall) begin
          instr_id_d = '0;
          valid_id_d = 1'b0;
        end
      end

      HOLD: begin
        if (fuif.flush) begin
          instr_id_d   = '0;
          pc_plus_id_d = '0;
          valid_id_d   = 1'b0;
          skid_clear   = 1'b1;
          state_d      = FETCH;
        end else if (fuif.halt) begin
          instr_id_d   = '0;
          pc_plus_id_d = '0;
          valid_id_d   = 1'b0;
          skid_clear   = 1'b1;
          state_d      = HALTED;
        end else if (!fuif.stall) begin
          instr_id_d    = skid_instr;
          pc_plus_id_d  = skid_pc_plus;
          valid_id_d    = 1'b1;
          fetch_count_d = fetch_count_q + word_t'(1);
          skid_clear    = 1'b1;
          state_d       = FETCH;
        end
      end

      HALTED: begin
        valid_id_d = 1'b0;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and IF/ID registers, all cleared asynchronously on reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= FETCH;
      instr_id_q    <= '0;
      pc_plus_id_q  <= '0;
      valid_id_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_id_q    <= instr_id_d;
      pc_plus_id_q  <= pc_plus_id_d;
      valid_id_q    <= valid_id_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fuif.imemREN     = imem_ren;
  assign fuif.imemaddr    = fuif.cpc;
  assign fuif.pc_wen      = pc_wen;
  assign fuif.instr_id    = instr_id_q;
  assign fuif.pc_plus_id  = pc_plus_id_q;
  assign fuif.valid_id    = valid_id_q;
  assign fuif.halted      = (state_q == HALTED);
  assign fuif.fetch_count = fetch_count_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_errors;

  fetch_if fif ();

  fetch_unit dut (
    .CLK  (CLK),
    .nRST (nRST),
    .fuif (fif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare one observed value against its hand-computed expectation
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, settle comb outputs
  task automatic drive(input logic [31:0] cpc, input logic [31:0] pcp, input logic [31:0] load,
                       input logic ihit, input logic stall, input logic flush, input logic halt);
    @(negedge CLK);
    fif.cpc      = cpc;
    fif.pc_plus  = pcp;
    fif.imemload = load;
    fif.ihit     = ihit;
    fif.stall    = stall;
    fif.flush    = flush;
    fif.halt     = halt;
    #1;
  endtask

  // Let the rising edge happen and settle registered outputs
  task automatic edge_settle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    nRST = 1'b0;
    fif.cpc = '0; fif.pc_plus = '0; fif.imemload = '0;
    fif.ihit = 1'b0; fif.stall = 1'b0; fif.flush = 1'b0; fif.halt = 1'b0;
    #12;
    check("rst_valid",   {31'b0, fif.valid_id}, 32'd0);
    check("rst_instr",   fif.instr_id, 32'd0);
    check("rst_count",   fif.fetch_count, 32'd0);
    check("rst_halted",  {31'b0, fif.halted}, 32'd0);
    check("rst_ren",     {31'b0, fif.imemREN}, 32'd1);
    @(negedge CLK);
    nRST = 1'b1;

    // Basic fetch
    drive(32'h0, 32'h4, 32'h2001000A, 1, 0, 0, 0);
    check("f1_pcwen", {31'b0, fif.pc_wen}, 32'd1);
    edge_settle();
    check("f1_instr", fif.instr_id, 32'h2001000A);
    check("f1_pcp",   fif.pc_plus_id, 32'h4);
    check("f1_valid", {31'b0, fif.valid_id}, 32'd1);
    check("f1_count", fif.fetch_count, 32'd1);

    // Stall with a hit: park in skid for three stalled cycles in total
    drive(32'h4, 32'h8, 32'h8C220004, 1, 1, 0, 0);
    check("s_pcwen0", {31'b0, fif.pc_wen}, 32'd1);
    edge_settle();
    check("s_instr0", fif.instr_id, 32'h2001000A);
    for (int i = 0; i < 2; i++) begin
      drive(32'h8, 32'hC, 32'hDEADBEEF, 1, 1, 0, 0);
      check("s_ren",   {31'b0, fif.imemREN}, 32'd0);
      check("s_pcwen", {31'b0, fif.pc_wen}, 32'd0);
      edge_settle();
      check("s_instr", fif.instr_id, 32'h2001000A);
      check("s_count", fif.fetch_count, 32'd1);
    end
    drive(32'h8, 32'hC, 32'hDEADBEEF, 0, 0, 0, 0);
    edge_settle();
    check("s_rel_instr", fif.instr_id, 32'h8C220004);
    check("s_rel_pcp",   fif.pc_plus_id, 32'h8);
    check("s_rel_count", fif.fetch_count, 32'd2);
    check("s_rel_ren",   {31'b0, fif.imemREN}, 32'd1);

    // Flush while holding and stalled
    drive(32'h8, 32'hC, 32'h11112222, 1, 1, 0, 0);
    edge_settle();
    drive(32'h40, 32'h44, 32'h0, 0, 1, 1, 0);
    check("fl_pcwen", {31'b0, fif.pc_wen}, 32'd1);
    edge_settle();
    check("fl_valid", {31'b0, fif.valid_id}, 32'd0);
    check("fl_instr", fif.instr_id, 32'd0);
    check("fl_pcp",   fif.pc_plus_id, 32'd0);
    check("fl_ren",   {31'b0, fif.imemREN}, 32'd1);
    drive(32'h40, 32'h44, 32'h0, 0, 0, 0, 0);
    edge_settle();
    check("fl_skid_gone", fif.instr_id, 32'd0);
    check("fl_count",     fif.fetch_count, 32'd2);

    // Halt and flush together: flush wins, same-cycle hit discarded
    drive(32'h44, 32'h48, 32'h55556666, 1, 0, 1, 1);
    check("hf_pcwen", {31'b0, fif.pc_wen}, 32'd1);
    edge_settle();
    check("hf_halted", {31'b0, fif.halted}, 32'd0);
    check("hf_ren",    {31'b0, fif.imemREN}, 32'd1);
    check("hf_count",  fif.fetch_count, 32'd2);
    check("hf_valid",  {31'b0, fif.valid_id}, 32'd0);
    drive(32'h60, 32'h64, 32'h33334444, 1, 0, 0, 0);
    edge_settle();
    check("hf_next_instr", fif.instr_id, 32'h33334444);
    check("hf_next_count", fif.fetch_count, 32'd3);

    // Halt alone
    drive(32'h64, 32'h68, 32'h77778888, 1, 0, 0, 1);
    check("h_pcwen", {31'b0, fif.pc_wen}, 32'd0);
    edge_settle();
    check("h_halted", {31'b0, fif.halted}, 32'd1);
    check("h_valid",  {31'b0, fif.valid_id}, 32'd0);
    check("h_instr",  fif.instr_id, 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(32'h64, 32'h68, 32'h99990000, 1, 0, (i == 5), 0);
      check("h_hold_halted", {31'b0, fif.halted}, 32'd1);
      check("h_hold_ren",    {31'b0, fif.imemREN}, 32'd0);
      check("h_hold_pcwen",  {31'b0, fif.pc_wen}, 32'd0);
      edge_settle();
      check("h_hold_valid",  {31'b0, fif.valid_id}, 32'd0);
    end
    check("h_count", fif.fetch_count, 32'd3);

    // Asynchronous reset out of HALTED
    drive(32'h20, 32'h24, 32'h0, 0, 0, 0, 0);
    nRST = 1'b0;
    #1;
    check("rh_halted", {31'b0, fif.halted}, 32'd0);
    check("rh_ren",    {31'b0, fif.imemREN}, 32'd1);
    check("rh_count",  fif.fetch_count, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // One fetch then four miss cycles
    drive(32'h20, 32'h24, 32'hAAAA0001, 1, 0, 0, 0);
    edge_settle();
    check("b_first", fif.instr_id, 32'hAAAA0001);
    for (int i = 0; i < 4; i++) begin
      drive(32'h24, 32'h28, 32'hFFFF0000, 0, 0, 0, 0);
      check("b_pcwen", {31'b0, fif.pc_wen}, 32'd0);
      edge_settle();
      check("b_valid", {31'b0, fif.valid_id}, 32'd0);
      check("b_instr", fif.instr_id, 32'd0);
    end
    check("b_count", fif.fetch_count, 32'd1);

    // Asynchronous reset in the middle of HOLD
    drive(32'h24, 32'h28, 32'hBBBB0002, 1, 1, 0, 0);
    edge_settle();
    drive(32'h28, 32'h2C, 32'h0, 0, 1, 0, 0);
    check("rhd_in_hold", {31'b0, fif.imemREN}, 32'd0);
    #1;
    nRST = 1'b0;
    #1;
    check("rhd_valid", {31'b0, fif.valid_id}, 32'd0);
    check("rhd_instr", fif.instr_id, 32'd0);
    check("rhd_pcp",   fif.pc_plus_id, 32'd0);
    check("rhd_count", fif.fetch_count, 32'd0);
    check("rhd_ren",   {31'b0, fif.imemREN}, 32'd1);
    @(negedge CLK);
    nRST = 1'b1;
    drive(32'h40, 32'h44, 32'h0, 0, 0, 0, 0);
    check("rhd_addr", fif.imemaddr, 32'h40);
    check("rhd_ren2", {31'b0, fif.imemREN}, 32'd1);
    edge_settle();
    check("rhd_nodeliver", {31'b0, fif.valid_id}, 32'd0);
    check("rhd_instr2",    fif.instr_id, 32'd0);
    check("rhd_count2",    fif.fetch_count, 32'd0);

    // Counter wrap from the all-ones preset
    @(negedge CLK);
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    #1;
    check("w_preset", fif.fetch_count, 32'hFFFF_FFFF);
    drive(32'h40, 32'h44, 32'h12345678, 1, 0, 0, 0);
    edge_settle();
    check("w_wrap",  fif.fetch_count, 32'h0);
    check("w_instr", fif.instr_id, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port nRST, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port cpc, input, word_t, current PC value from the PC register.
REQ-004 SHALL have port pc_plus, input, word_t, cpc + WBYTES from the PC block.
REQ-005 SHALL have port imemload, input, word_t, instruction word returned by the instruction cache.
REQ-006 SHALL have port ihit, input, 1, cache hit; imemload is valid when high.
REQ-007 SHALL have port stall, input, 1, decode/hazard unit cannot accept a new instruction.
REQ-008 SHALL have port flush, input, 1, taken branch/jump redirect; discard younger instructions.
REQ-009 SHALL have port halt, input, 1, halt opcode decoded in ID.
REQ-010 SHALL have port imemREN, output, 1, instruction read enable.
REQ-011 SHALL have port imemaddr, output, word_t, instruction fetch address.
REQ-012 SHALL have port pc_wen, output, 1, PC register write enable.
REQ-013 SHALL have port instr_id, output, word_t, IF/ID instruction register.
REQ-014 SHALL have port pc_plus_id, output, word_t, IF/ID copy of pc_plus.
REQ-015 SHALL have port valid_id, output, 1, IF/ID holds a real instruction.
REQ-016 SHALL have port halted, output, 1, fetch permanently stopped.
REQ-017 SHALL have port fetch_count, output, word_t, count of instructions delivered to ID.

Function
REQ-018 SHALL implement FSM states FETCH, HOLD, HALTED; reset state FETCH.
REQ-019 SHALL drive imemREN=1 and imemaddr=cpc in FETCH; imemREN=0 and imemaddr=cpc in HOLD and HALTED.
REQ-020 SHALL drive pc_wen=1 combinationally when flush=1 (not HALTED), or when state=FETCH and ihit=1 and halt=0; else 0.
REQ-021 SHALL, in FETCH with ihit=1, stall=0, flush=0, halt=0: load instr_id<=imemload, pc_plus_id<=pc_plus, valid_id<=1, increment fetch_count; stay FETCH.
REQ-022 SHALL, in FETCH with ihit=1, stall=1, flush=0: capture imemload/pc_plus into skid buffer, hold IF/ID, go HOLD.
REQ-023 SHALL, in FETCH with ihit=0 and stall=0: load valid_id<=0, instr_id<=0 (bubble); with stall=1 hold IF/ID.
REQ-024 SHALL, in HOLD with stall=0: move skid buffer into IF/ID, valid_id<=1, increment fetch_count, go FETCH; with stall=1 hold everything.
REQ-025 SHALL, on flush=1 in FETCH or HOLD: clear IF/ID (instr_id=0, pc_plus_id=0, valid_id=0), discard skid buffer and any same-cycle ihit data, go FETCH; flush overrides stall.
REQ-026 SHALL, on halt=1 with flush=0 in FETCH or HOLD: clear IF/ID, go HALTED; flush=1 wins over halt (halt ignored that cycle).
REQ-027 SHALL in HALTED drive halted=1, pc_wen=0, imemREN=0, valid_id=0; leave only via reset.
REQ-028 SHALL wrap fetch_count modulo 2^WORD_W without saturation.
REQ-029 SHALL give a single-cycle fetch-to-ID latency: instruction accepted at edge N appears on instr_id after edge N.

Reset
REQ-030 SHALL on nRST=0 immediately set state=FETCH, instr_id=0, pc_plus_id=0, valid_id=0, fetch_count=0, skid buffer=0, halted=0.
REQ-031 SHALL, on reset asserted mid-HOLD or mid-HALTED, drop all buffered data with no instruction delivered.

Structure
REQ-032 SHALL take word_t, WORD_W, WBYTES from cpu_types_pkg; fetch_state_t enum (FETCH, HOLD, HALTED) SHALL be added to cpu_types_pkg.
REQ-033 SHALL group ports in interface fetch_if with modport fu matching REQ-001..017 directions.
REQ-034 SHALL place the one-entry skid buffer in sub-module fetch_skid (load, clear, data out).

Verification
REQ-035 Reset then ihit=1, imemload=0x2001000A, cpc=0, pc_plus=4 -> pc_wen=1, next cycle instr_id=0x2001000A, pc_plus_id=4, valid_id=1, fetch_count=1.
REQ-036 FETCH ihit=1 imemload=0x8C220004 with stall=1 for 3 cycles -> state HOLD, imemREN=0, IF/ID unchanged; stall drops -> instr_id=0x8C220004 next cycle, fetch_count +1.
REQ-037 HOLD with flush=1 and stall=1 together -> valid_id=0, instr_id=0, skid discarded, state FETCH, pc_wen=1 that cycle.
REQ-038 halt=1 and flush=1 same cycle -> flush wins, state FETCH; later halt=1 alone -> halted=1, imemREN=0, pc_wen=0 held for 10 cycles despite ihit=1.
REQ-039 ihit=0 for 4 cycles, stall=0 -> valid_id=0 bubbles, pc_wen=0, fetch_count unchanged; fetch_count preset path 0xFFFFFFFF +1 -> 0x00000000.
REQ-040 nRST asserted mid-HOLD -> all outputs at reset values asynchronously; after release state FETCH, imemREN=1, imemaddr=cpc.
